// File: rtl/vga_pattern_sequencer_if.sv
// Host-side bundle for the VGA pattern sequencer: pause/step handshake plus
// the timing, sync and colour outputs of the pixel domain.
interface vga_pattern_sequencer_if;
    logic        pause;
    logic        step_req;
    logic        step_ack;
    logic [15:0] H_counter;
    logic [15:0] V_counter;
    logic        Hsync;
    logic        Vsync;
    logic        Red;
    logic        Green;
    logic        Blue;
    logic        frame_start;
    logic [2:0]  color_idx;

    modport master (
        output pause, step_req,
        input  step_ack, H_counter, V_counter, Hsync, Vsync,
               Red, Green, Blue, frame_start, color_idx
    );

    modport slave (
        input  pause, step_req,
        output step_ack, H_counter, V_counter, Hsync, Vsync,
               Red, Green, Blue, frame_start, color_idx
    );
endinterface

// File: rtl/vga_pattern_sequencer.sv
// 640x480@60 VGA timing generator with an 8-colour test pattern that only
// changes colour on frame boundaries; dwell, pause and manual step control.
module vga_pattern_sequencer #(
    parameter int H_TOTAL         = 800,
    parameter int V_TOTAL         = 525,
    parameter int FRAMES_PER_STEP = 60,
    parameter int H_SYNC_LEN      = 96,
    parameter int H_ACT_START     = 144,
    parameter int H_ACT_END       = 784,
    parameter int V_SYNC_LEN      = 2,
    parameter int V_ACT_START     = 35,
    parameter int V_ACT_END       = 515
) (
    input  logic                    clk_25MHz,
    input  logic                    rst_n,
    vga_pattern_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_WHITE   = 3'd0,
        ST_RED     = 3'd1,
        ST_YELLOW  = 3'd2,
        ST_GREEN   = 3'd3,
        ST_CYAN    = 3'd4,
        ST_BLUE    = 3'd5,
        ST_MAGENTA = 3'd6,
        ST_BLACK   = 3'd7
    } state_t;

    localparam int DWELL_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

    logic [15:0]        h_q, v_q;
    logic               h_last, v_last, boundary, active;
    state_t             state_q, state_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               pending_q, pending_d;
    logic               take_step, advance;
    logic [2:0]         color_q, color_d, rgb_q;
    logic               hsync_q, vsync_q, frame_start_q;

    // Colour word: bit 0 red, bit 1 green, bit 2 blue.
    function automatic logic [2:0] color_of(state_t s);
        case (s)
            ST_WHITE:   return 3'b111;
            ST_RED:     return 3'b001;
            ST_YELLOW:  return 3'b011;
            ST_GREEN:   return 3'b010;
            ST_CYAN:    return 3'b110;
            ST_BLUE:    return 3'b100;
            ST_MAGENTA: return 3'b101;
            ST_BLACK:   return 3'b000;
            default:    return 3'b000;
        endcase
    endfunction

    assign h_last   = (h_q == 16'(H_TOTAL - 1));
    assign v_last   = (v_q == 16'(V_TOTAL - 1));
    assign boundary = h_last && v_last;
    assign active   = (h_q >= 16'(H_ACT_START)) && (h_q < 16'(H_ACT_END)) &&
                      (v_q >= 16'(V_ACT_START)) && (v_q < 16'(V_ACT_END));

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        state_d   = state_q;
        dwell_d   = dwell_q;
        pending_d = pending_q | bus.step_req;
        take_step = 1'b0;
        advance   = 1'b0;

        if (boundary) begin
            if (pending_q) begin
                // A pending request wins over pause and merges with dwell expiry.
                take_step = 1'b1;
                advance   = 1'b1;
                dwell_d   = '0;
                pending_d = bus.step_req;
            end else if (!bus.pause) begin
                if (dwell_q == DWELL_W'(FRAMES_PER_STEP - 1)) begin
                    advance = 1'b1;
                    dwell_d = '0;
                end else begin
                    dwell_d = dwell_q + DWELL_W'(1);
                end
            end
        end

        if (advance) state_d = state_t'(state_q + 3'd1);
        color_d = color_of(state_d);
    end

    always_ff @(posedge clk_25MHz) begin
        // NOTE: reset is sampled on the clock edge only; registers use non-blocking assignment.
        if (!rst_n) begin
            h_q           <= '0;
            v_q           <= '0;
            state_q       <= ST_WHITE;
            dwell_q       <= '0;
            pending_q     <= 1'b0;
            color_q       <= 3'b111;
            rgb_q         <= 3'b000;
            hsync_q       <= 1'b0;
            vsync_q       <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            h_q <= h_last ? '0 : h_q + 16'd1;
            if (h_last) v_q <= v_last ? '0 : v_q + 16'd1;

            hsync_q       <= (h_q < 16'(H_SYNC_LEN));
            vsync_q       <= (v_q < 16'(V_SYNC_LEN));
            frame_start_q <= (h_q == 16'd0) && (v_q == 16'd0);
            rgb_q         <= active ? color_q : 3'b000;

            state_q   <= state_d;
            dwell_q   <= dwell_d;
            pending_q <= pending_d;
            color_q   <= color_d;
        end
    end

    assign bus.H_counter   = h_q;
    assign bus.V_counter   = v_q;
    assign bus.Hsync       = hsync_q;
    assign bus.Vsync       = vsync_q;
    assign bus.Red         = rgb_q[0];
    assign bus.Green       = rgb_q[1];
    assign bus.Blue        = rgb_q[2];
    assign bus.frame_start = frame_start_q;
    assign bus.color_idx   = state_q;
    assign bus.step_ack    = take_step;

endmodule

// File: tb/tb_vga_pattern_sequencer.sv
// Self-checking bench for vga_pattern_sequencer on a shrunken raster so the
// pattern sequence, pause, step handshake and reset cases run in few cycles.
module tb_vga_pattern_sequencer;

    localparam int HT    = 40;
    localparam int VT    = 20;
    localparam int FPS   = 2;
    localparam int HS    = 4;
    localparam int HA0   = 8;
    localparam int HA1   = 36;
    localparam int VS    = 2;
    localparam int VA0   = 3;
    localparam int VA1   = 18;
    localparam int FRAME = HT * VT;

    localparam logic [2:0] COLORS [8] = '{3'b111, 3'b001, 3'b011, 3'b010,
                                          3'b110, 3'b100, 3'b101, 3'b000};

    logic clk_25MHz = 1'b0;
    logic rst_n     = 1'b0;
    always #20 clk_25MHz = ~clk_25MHz;

    vga_pattern_sequencer_if bus ();

    vga_pattern_sequencer #(
        .H_TOTAL(HT), .V_TOTAL(VT), .FRAMES_PER_STEP(FPS),
        .H_SYNC_LEN(HS), .H_ACT_START(HA0), .H_ACT_END(HA1),
        .V_SYNC_LEN(VS), .V_ACT_START(VA0), .V_ACT_END(VA1)
    ) u_dut (
        .clk_25MHz(clk_25MHz),
        .rst_n(rst_n),
        .bus(bus)
    );

    int errors   = 0;
    int checks   = 0;
    int scan_bad = 0;
    int timeouts = 0;
    bit mon_en   = 0;

    // Reference model: raster position as a single frame offset, pattern as
    // an index into the colour table, requests as a pending flag.
    int       m_pos, m_state, m_dwell;
    bit       m_pending, m_hs, m_vs, m_fs;
    logic [2:0] m_rgb;

    function automatic bit in_window(int pos);
        int h = pos % HT;
        int v = pos / HT;
        return (h >= HA0) && (h < HA1) && (v >= VA0) && (v < VA1);
    endfunction

    always @(posedge clk_25MHz) begin
        if (!rst_n) begin
            m_pos <= 0; m_state <= 0; m_dwell <= 0; m_pending <= 0;
            m_hs <= 0; m_vs <= 0; m_fs <= 0; m_rgb <= 3'b000;
        end else begin
            m_hs  <= (m_pos % HT) < HS;
            m_vs  <= (m_pos / HT) < VS;
            m_fs  <= (m_pos == 0);
            m_rgb <= in_window(m_pos) ? COLORS[m_state] : 3'b000;
            if (m_pos == FRAME - 1) begin
                if (m_pending || (!bus.pause && m_dwell == FPS - 1)) begin
                    m_state <= (m_state + 1) % 8;
                    m_dwell <= 0;
                end else if (!bus.pause) begin
                    m_dwell <= m_dwell + 1;
                end
                m_pending <= bus.step_req;
            end else begin
                m_pending <= m_pending || bus.step_req;
            end
            m_pos <= (m_pos + 1) % FRAME;
        end
    end

    always @(negedge clk_25MHz) begin
        if (mon_en) begin
            if (bus.H_counter !== 16'(m_pos % HT) || bus.V_counter !== 16'(m_pos / HT) ||
                bus.Hsync !== m_hs || bus.Vsync !== m_vs || bus.frame_start !== m_fs ||
                {bus.Blue, bus.Green, bus.Red} !== m_rgb ||
                bus.color_idx !== 3'(m_state) ||
                bus.step_ack !== ((m_pos == FRAME - 1) && m_pending))
                scan_bad++;
        end
    end

    task automatic tick(int n);
        repeat (n) @(negedge clk_25MHz);
    endtask

    task automatic wait_pos(int h, int v);
        int k = 0;
        while (!(bus.H_counter == 16'(h) && bus.V_counter == 16'(v))) begin
            if (k > 2 * FRAME) begin
                timeouts++;
                return;
            end
            @(negedge clk_25MHz);
            k++;
        end
    endtask

    task automatic do_reset(int n);
        rst_n = 1'b0;
        tick(n);
        rst_n = 1'b1;
    endtask

    task automatic pulse_req();
        bus.step_req = 1'b1;
        tick(1);
        bus.step_req = 1'b0;
    endtask

    task automatic test_reset();
        int bad0 = scan_bad, to0 = timeouts, dark = 0;
        bus.pause = 1'b0; bus.step_req = 1'b0; rst_n = 1'b0;
        tick(1);
        mon_en = 1;
        tick(2);
        rst_n = 1'b1;
        checks++; if (bus.H_counter !== 16'd0) begin errors++; $display("FAIL reset_h: got %0d, expected 0", bus.H_counter); end
        checks++; if (bus.V_counter !== 16'd0) begin errors++; $display("FAIL reset_v: got %0d, expected 0", bus.V_counter); end
        checks++; if ({bus.Hsync, bus.Vsync, bus.Red, bus.Green, bus.Blue, bus.frame_start, bus.step_ack} !== 7'b0) begin
            errors++; $display("FAIL reset_outs: got %b, expected 0000000",
                {bus.Hsync, bus.Vsync, bus.Red, bus.Green, bus.Blue, bus.frame_start, bus.step_ack}); end
        checks++; if (bus.color_idx !== 3'd0) begin errors++; $display("FAIL reset_idx: got %0d, expected 0", bus.color_idx); end
        for (int k = 0; k < (VA0 * HT + HA0); k++) begin
            if ({bus.Blue, bus.Green, bus.Red} !== 3'b000) dark++;
            tick(1);
        end
        checks++; if (dark != 0) begin errors++; $display("FAIL reset_dark: %0d lit cycles before window, expected 0", dark); end
        tick(1);
        checks++; if ({bus.Red, bus.Green, bus.Blue} !== 3'b111) begin
            errors++; $display("FAIL reset_first_pixel: got %b, expected 111", {bus.Red, bus.Green, bus.Blue}); end
        checks++; if (scan_bad != bad0) begin errors++; $display("FAIL reset_model: %0d cycles differ, expected 0", scan_bad - bad0); end
        checks++; if (timeouts != to0) begin errors++; $display("FAIL reset_timeout: %0d waits expired, expected 0", timeouts - to0); end
    endtask

    task automatic test_timing();
        int bad0 = scan_bad, to0 = timeouts;
        int hs_cnt = 0, vs_cnt = 0, fs_cnt = 0, fs_a = -1, fs_b = -1;
        logic [2:0] edge_rgb [4];
        wait_pos(0, 0);
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (bus.Hsync) hs_cnt++;
            if (bus.Vsync) vs_cnt++;
            if (bus.frame_start) begin
                fs_cnt++;
                if (fs_a < 0) fs_a = i; else fs_b = i;
            end
            if (i < FRAME && bus.V_counter == 16'(VA0 + 5)) begin
                if (bus.H_counter == 16'(HA0))     edge_rgb[0] = {bus.Blue, bus.Green, bus.Red};
                if (bus.H_counter == 16'(HA0 + 1)) edge_rgb[1] = {bus.Blue, bus.Green, bus.Red};
                if (bus.H_counter == 16'(HA1))     edge_rgb[2] = {bus.Blue, bus.Green, bus.Red};
                if (bus.H_counter == 16'(HA1 + 1)) edge_rgb[3] = {bus.Blue, bus.Green, bus.Red};
            end
            tick(1);
        end
        checks++; if (hs_cnt != 2 * VT * HS) begin errors++; $display("FAIL hsync_width: got %0d, expected %0d", hs_cnt, 2 * VT * HS); end
        checks++; if (vs_cnt != 2 * VS * HT) begin errors++; $display("FAIL vsync_width: got %0d, expected %0d", vs_cnt, 2 * VS * HT); end
        checks++; if (fs_cnt != 2) begin errors++; $display("FAIL frame_start_count: got %0d, expected 2", fs_cnt); end
        checks++; if (fs_b - fs_a != FRAME) begin errors++; $display("FAIL frame_start_period: got %0d, expected %0d", fs_b - fs_a, FRAME); end
        checks++; if (edge_rgb[0] !== 3'b000) begin errors++; $display("FAIL rgb_left_blank: got %b, expected 000", edge_rgb[0]); end
        checks++; if (edge_rgb[1] !== COLORS[0]) begin errors++; $display("FAIL rgb_left_active: got %b, expected %b", edge_rgb[1], COLORS[0]); end
        checks++; if (edge_rgb[2] !== COLORS[0]) begin errors++; $display("FAIL rgb_right_active: got %b, expected %b", edge_rgb[2], COLORS[0]); end
        checks++; if (edge_rgb[3] !== 3'b000) begin errors++; $display("FAIL rgb_right_blank: got %b, expected 000", edge_rgb[3]); end
        checks++; if (scan_bad != bad0) begin errors++; $display("FAIL timing_model: %0d cycles differ, expected 0", scan_bad - bad0); end
        checks++; if (timeouts != to0) begin errors++; $display("FAIL timing_timeout: %0d waits expired, expected 0", timeouts - to0); end
    endtask

    task automatic test_auto_sequence();
        int bad0 = scan_bad, to0 = timeouts, exp_s;
        bus.pause = 1'b0;
        do_reset(2);
        for (int f = 0; f <= 8 * FPS; f++) begin
            tick(1);
            wait_pos(21, 10);
            exp_s = (f / FPS) % 8;
            checks++; if (bus.color_idx !== 3'(exp_s)) begin
                errors++; $display("FAIL auto_idx frame %0d: got %0d, expected %0d", f, bus.color_idx, exp_s); end
            checks++; if ({bus.Blue, bus.Green, bus.Red} !== COLORS[exp_s]) begin
                errors++; $display("FAIL auto_rgb frame %0d: got %b, expected %b", f, {bus.Blue, bus.Green, bus.Red}, COLORS[exp_s]); end
        end
        checks++; if (scan_bad != bad0) begin errors++; $display("FAIL auto_model: %0d cycles differ, expected 0", scan_bad - bad0); end
        checks++; if (timeouts != to0) begin errors++; $display("FAIL auto_timeout: %0d waits expired, expected 0", timeouts - to0); end
    endtask

    task automatic test_pause_step();
        int bad0 = scan_bad, to0 = timeouts, acks = 0, ack_h = -1, ack_v = -1;
        bus.pause = 1'b1;
        do_reset(2);
        tick(5 * FRAME + $urandom_range(0, HT - 1));
        checks++; if (bus.color_idx !== 3'd0) begin errors++; $display("FAIL pause_hold: got %0d, expected 0", bus.color_idx); end
        wait_pos($urandom_range(1, HT - 2), $urandom_range(1, VT - 2));
        pulse_req();
        for (int k = 0; k < 2 * FRAME && ack_h < 0; k++) begin
            if (bus.step_ack) begin ack_h = bus.H_counter; ack_v = bus.V_counter; end
            else tick(1);
        end
        checks++; if (ack_h != HT - 1 || ack_v != VT - 1) begin
            errors++; $display("FAIL step_ack_pos: got (%0d,%0d), expected (%0d,%0d)", ack_h, ack_v, HT - 1, VT - 1); end
        tick(1);
        checks++; if (bus.color_idx !== 3'd1) begin errors++; $display("FAIL step_advance: got %0d, expected 1", bus.color_idx); end
        wait_pos(5, 2);  pulse_req();
        wait_pos(30, 8); pulse_req();
        wait_pos(10, 15); pulse_req();
        for (int k = 0; k < 2 * FRAME; k++) begin
            if (bus.step_ack) acks++;
            tick(1);
        end
        checks++; if (acks != 1) begin errors++; $display("FAIL step_merge_acks: got %0d, expected 1", acks); end
        checks++; if (bus.color_idx !== 3'd2) begin errors++; $display("FAIL step_merge_idx: got %0d, expected 2", bus.color_idx); end
        bus.pause = 1'b0;
        checks++; if (scan_bad != bad0) begin errors++; $display("FAIL step_model: %0d cycles differ, expected 0", scan_bad - bad0); end
        checks++; if (timeouts != to0) begin errors++; $display("FAIL step_timeout: %0d waits expired, expected 0", timeouts - to0); end
    endtask

    task automatic test_collision();
        int bad0 = scan_bad, to0 = timeouts;
        bus.pause = 1'b0;
        do_reset(2);
        tick(FRAME);
        wait_pos($urandom_range(0, HT - 1), $urandom_range(1, VT - 2));
        pulse_req();
        wait_pos(HT - 1, VT - 1);
        checks++; if (bus.step_ack !== 1'b1) begin errors++; $display("FAIL collide_ack: got %b, expected 1", bus.step_ack); end
        tick(1);
        checks++; if (bus.color_idx !== 3'd1) begin errors++; $display("FAIL collide_single: got %0d, expected 1", bus.color_idx); end
        wait_pos(HT - 1, VT - 1);
        checks++; if (bus.step_ack !== 1'b0) begin errors++; $display("FAIL collide_dwell_cleared_ack: got %b, expected 0", bus.step_ack); end
        tick(1);
        checks++; if (bus.color_idx !== 3'd1) begin errors++; $display("FAIL collide_dwell_cleared: got %0d, expected 1", bus.color_idx); end
        bus.pause = 1'b1;
        wait_pos(HT - 1, VT - 1);
        checks++; if (bus.step_ack !== 1'b0) begin errors++; $display("FAIL late_req_idle_ack: got %b, expected 0", bus.step_ack); end
        pulse_req();
        checks++; if (bus.color_idx !== 3'd1) begin errors++; $display("FAIL late_req_not_taken: got %0d, expected 1", bus.color_idx); end
        wait_pos(HT - 1, VT - 1);
        checks++; if (bus.step_ack !== 1'b1) begin errors++; $display("FAIL late_req_ack: got %b, expected 1", bus.step_ack); end
        tick(1);
        checks++; if (bus.color_idx !== 3'd2) begin errors++; $display("FAIL late_req_taken: got %0d, expected 2", bus.color_idx); end
        bus.pause = 1'b0;
        checks++; if (scan_bad != bad0) begin errors++; $display("FAIL collide_model: %0d cycles differ, expected 0", scan_bad - bad0); end
        checks++; if (timeouts != to0) begin errors++; $display("FAIL collide_timeout: %0d waits expired, expected 0", timeouts - to0); end
    endtask

    task automatic test_mid_reset();
        int bad0 = scan_bad, to0 = timeouts;
        bus.pause = 1'b0;
        tick(FRAME);
        wait_pos(20, 12);
        do_reset(1);
        checks++; if (bus.H_counter !== 16'd0 || bus.V_counter !== 16'd0) begin
            errors++; $display("FAIL midrst_counters: got (%0d,%0d), expected (0,0)", bus.H_counter, bus.V_counter); end
        checks++; if (bus.color_idx !== 3'd0) begin errors++; $display("FAIL midrst_idx: got %0d, expected 0", bus.color_idx); end
        wait_pos(HA0 + 1, VA0);
        checks++; if ({bus.Red, bus.Green, bus.Blue} !== 3'b111) begin
            errors++; $display("FAIL midrst_color: got %b, expected 111", {bus.Red, bus.Green, bus.Blue}); end
        wait_pos(HT - 1, VT - 1);
        tick(1);
        checks++; if (bus.color_idx !== 3'd0) begin errors++; $display("FAIL midrst_dwell_one: got %0d, expected 0", bus.color_idx); end
        wait_pos(HT - 1, VT - 1);
        tick(1);
        checks++; if (bus.color_idx !== 3'd1) begin errors++; $display("FAIL midrst_dwell_two: got %0d, expected 1", bus.color_idx); end
        checks++; if (scan_bad != bad0) begin errors++; $display("FAIL midrst_model: %0d cycles differ, expected 0", scan_bad - bad0); end
        checks++; if (timeouts != to0) begin errors++; $display("FAIL midrst_timeout: %0d waits expired, expected 0", timeouts - to0); end
    endtask

    initial begin
        bus.pause    = 1'b0;
        bus.step_req = 1'b0;
        test_reset();
        test_timing();
        test_auto_sequence();
        test_pause_step();
        test_collision();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
